// File: rtl/rnn_pkg.sv
// Shared constants, state encoding and width helpers for the LSTM gate operand path.
package rnn_pkg;

    localparam int DEF_INPUT_SZ  = 8;
    localparam int DEF_HIDDEN_SZ = 16;
    localparam int DEF_QN        = 6;
    localparam int DEF_QM        = 11;

    localparam logic [1:0] WR_SEL_X    = 2'd0;
    localparam logic [1:0] WR_SEL_Y    = 2'd1;
    localparam logic [1:0] WR_SEL_BIAS = 2'd2;
    localparam logic [1:0] WR_SEL_RSVD = 2'd3;

    typedef enum logic [2:0] {
        LOAD_X,
        LOAD_H,
        KICK,
        WAIT,
        HOLD
    } feederState_t;

    function automatic int calcBitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    function automatic int calcLayerBitwidth(input int bitwidth, input int hiddenSz);
        return bitwidth * hiddenSz;
    endfunction

    // Never returns less than 1 so that single-entry memories still get an address bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/gate_feeder_col_ram.sv
// Weight column memory: one synchronous write port, one asynchronous read port, no reset.
module col_ram
    import rnn_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 288,
    parameter int AW    = clog2(DEPTH)
)(
    input  logic             clock,
    input  logic             i_wrEn,
    input  logic [AW-1:0]    i_wrAddr,
    input  logic [WIDTH-1:0] i_wrData,
    input  logic [AW-1:0]    i_rdAddr,
    output logic [WIDTH-1:0] o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wrInRange;
    logic             w_rdInRange;

    // A non-power-of-2 depth leaves unused addresses: writes there are ignored, reads return 0.
    generate
        if (DEPTH == (1 << AW)) begin : gFullRange
            assign w_wrInRange = 1'b1;
            assign w_rdInRange = 1'b1;
        end else begin : gPartialRange
            assign w_wrInRange = (32'(i_wrAddr) < DEPTH);
            assign w_rdInRange = (32'(i_rdAddr) < DEPTH);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (i_wrEn && w_wrInRange) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = w_rdInRange ? r_mem[i_rdAddr] : '0;

endmodule

// File: rtl/gate_feeder.sv
// Operand server and sequencer for one LSTM gate: buffers x_t / h_{t-1}, holds weights and bias,
// kicks the gate, and hands its result downstream over a valid/ready port.
module gate_feeder
    import rnn_pkg::*;
#(
    parameter int INPUT_SZ       = DEF_INPUT_SZ,
    parameter int HIDDEN_SZ      = DEF_HIDDEN_SZ,
    parameter int QN             = DEF_QN,
    parameter int QM             = DEF_QM,
    parameter int BITWIDTH       = calcBitwidth(QN, QM),
    parameter int LAYER_BITWIDTH = calcLayerBitwidth(BITWIDTH, HIDDEN_SZ),
    parameter int AW_X           = clog2(INPUT_SZ),
    parameter int AW_Y           = clog2(HIDDEN_SZ)
)(
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      vec_valid,
    input  logic [BITWIDTH-1:0]       vec_data,
    output logic                      vec_ready,

    input  logic                      wr_en,
    input  logic [1:0]                wr_sel,
    input  logic [AW_Y-1:0]           wr_addr,
    input  logic [LAYER_BITWIDTH-1:0] wr_data,
    output logic                      wr_err,

    input  logic [AW_X-1:0]           colAddress_X,
    input  logic [AW_Y-1:0]           colAddress_Y,
    output logic [BITWIDTH-1:0]       inputVec,
    output logic [BITWIDTH-1:0]       prevLayerOut,
    output logic [LAYER_BITWIDTH-1:0] weightMem_X,
    output logic [LAYER_BITWIDTH-1:0] weightMem_Y,
    output logic [LAYER_BITWIDTH-1:0] biasVec,

    output logic                      beginCalc,
    input  logic                      dataReady_gate,
    input  logic [LAYER_BITWIDTH-1:0] gateOutput,

    output logic                      res_valid,
    output logic [LAYER_BITWIDTH-1:0] res_data,
    input  logic                      res_ready,

    output logic                      busy
);

    localparam int CNT_W = (AW_X > AW_Y) ? AW_X : AW_Y;

    feederState_t              r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [BITWIDTH-1:0]       r_xBuf [INPUT_SZ];
    logic [BITWIDTH-1:0]       r_hBuf [HIDDEN_SZ];
    logic [LAYER_BITWIDTH-1:0] r_bias;
    logic [LAYER_BITWIDTH-1:0] r_resData;
    logic                      r_vecReady;
    logic                      r_beginCalc;
    logic                      r_resValid;
    logic                      r_wrErr;
    logic                      r_busy;

    logic                      w_loading;
    logic                      w_vecAccept;
    logic                      w_wrAccept;
    logic                      w_wrDrop;
    logic                      w_wrX;
    logic                      w_wrY;
    logic                      w_lastX;
    logic                      w_lastH;

    // Writes are only honoured while loading, which is what keeps every operand frozen
    // from the kick until the result has been handed off.
    assign w_loading   = (r_state == LOAD_X) || (r_state == LOAD_H);
    assign w_vecAccept = vec_valid && r_vecReady;
    assign w_wrAccept  = wr_en && w_loading && (wr_sel != WR_SEL_RSVD);
    assign w_wrDrop    = wr_en && !w_wrAccept;
    assign w_wrX       = w_wrAccept && (wr_sel == WR_SEL_X);
    assign w_wrY       = w_wrAccept && (wr_sel == WR_SEL_Y);
    assign w_lastX     = (r_cnt == CNT_W'(INPUT_SZ - 1));
    assign w_lastH     = (r_cnt == CNT_W'(HIDDEN_SZ - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= LOAD_X;
            r_cnt       <= '0;
            r_bias      <= '0;
            r_resData   <= '0;
            r_vecReady  <= 1'b0;
            r_beginCalc <= 1'b0;
            r_resValid  <= 1'b0;
            r_wrErr     <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < INPUT_SZ; i++) begin
                r_xBuf[i] <= '0;
            end
            for (int i = 0; i < HIDDEN_SZ; i++) begin
                r_hBuf[i] <= '0;
            end
        end else begin
            r_wrErr <= w_wrDrop;
            if (w_wrAccept && (wr_sel == WR_SEL_BIAS)) begin
                r_bias <= wr_data;
            end

            // Handshake outputs are registered, so each transition also sets what the
            // next state presents on vec_ready / beginCalc / res_valid / busy.
            case (r_state)
                LOAD_X: begin
                    r_vecReady <= 1'b1;
                    if (w_vecAccept) begin
                        r_xBuf[r_cnt[AW_X-1:0]] <= vec_data;
                        if (w_lastX) begin
                            r_cnt   <= '0;
                            r_state <= LOAD_H;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                LOAD_H: begin
                    if (w_vecAccept) begin
                        r_hBuf[r_cnt[AW_Y-1:0]] <= vec_data;
                        if (w_lastH) begin
                            r_cnt       <= '0;
                            r_vecReady  <= 1'b0;
                            r_beginCalc <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= KICK;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                KICK: begin
                    r_beginCalc <= 1'b0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (dataReady_gate) begin
                        r_resData  <= gateOutput;
                        r_resValid <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        r_resValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_vecReady <= 1'b1;
                        r_state    <= LOAD_X;
                    end
                end
                default: begin
                    r_state <= LOAD_X;
                end
            endcase
        end
    end

    col_ram #(
        .DEPTH (INPUT_SZ),
        .WIDTH (LAYER_BITWIDTH),
        .AW    (AW_X)
    ) uRamX (
        .clock    (clock),
        .i_wrEn   (w_wrX),
        .i_wrAddr (wr_addr[AW_X-1:0]),
        .i_wrData (wr_data),
        .i_rdAddr (colAddress_X),
        .o_rdData (weightMem_X)
    );

    col_ram #(
        .DEPTH (HIDDEN_SZ),
        .WIDTH (LAYER_BITWIDTH),
        .AW    (AW_Y)
    ) uRamY (
        .clock    (clock),
        .i_wrEn   (w_wrY),
        .i_wrAddr (wr_addr),
        .i_wrData (wr_data),
        .i_rdAddr (colAddress_Y),
        .o_rdData (weightMem_Y)
    );

    // The gate samples in the same cycle it drives an address, so reads carry no latency.
    generate
        if (INPUT_SZ == (1 << AW_X)) begin : gXFull
            assign inputVec = r_xBuf[colAddress_X];
        end else begin : gXPartial
            assign inputVec = (32'(colAddress_X) < INPUT_SZ) ? r_xBuf[colAddress_X] : '0;
        end
    endgenerate

    assign prevLayerOut = r_hBuf[colAddress_Y];
    assign biasVec      = r_bias;
    assign vec_ready    = r_vecReady;
    assign beginCalc    = r_beginCalc;
    assign res_valid    = r_resValid;
    assign res_data     = r_resData;
    assign wr_err       = r_wrErr;
    assign busy         = r_busy;

endmodule

// File: tb/tb_gate_feeder.sv
// Directed bench for gate_feeder: weight load, operand streaming, gate handshake,
// dropped writes and mid-operation reset.
module tb_gate_feeder;

    localparam int INPUT_SZ  = 8;
    localparam int HIDDEN_SZ = 16;
    localparam int BW        = 18;
    localparam int LW        = BW * HIDDEN_SZ;
    localparam int AWX       = 3;
    localparam int AWY       = 4;

    logic              clock;
    logic              reset;
    logic              vec_valid;
    logic [BW-1:0]     vec_data;
    logic              vec_ready;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [AWY-1:0]    wr_addr;
    logic [LW-1:0]     wr_data;
    logic              wr_err;
    logic [AWX-1:0]    colAddress_X;
    logic [AWY-1:0]    colAddress_Y;
    logic [BW-1:0]     inputVec;
    logic [BW-1:0]     prevLayerOut;
    logic [LW-1:0]     weightMem_X;
    logic [LW-1:0]     weightMem_Y;
    logic [LW-1:0]     biasVec;
    logic              beginCalc;
    logic              dataReady_gate;
    logic [LW-1:0]     gateOutput;
    logic              res_valid;
    logic [LW-1:0]     res_data;
    logic              res_ready;
    logic              busy;

    int nVectors;
    int nMiscompares;

    gate_feeder dut (
        .clock          (clock),
        .reset          (reset),
        .vec_valid      (vec_valid),
        .vec_data       (vec_data),
        .vec_ready      (vec_ready),
        .wr_en          (wr_en),
        .wr_sel         (wr_sel),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_err         (wr_err),
        .colAddress_X   (colAddress_X),
        .colAddress_Y   (colAddress_Y),
        .inputVec       (inputVec),
        .prevLayerOut   (prevLayerOut),
        .weightMem_X    (weightMem_X),
        .weightMem_Y    (weightMem_Y),
        .biasVec        (biasVec),
        .beginCalc      (beginCalc),
        .dataReady_gate (dataReady_gate),
        .gateOutput     (gateOutput),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_ready      (res_ready),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [LW-1:0] splat(input int value);
        logic [LW-1:0] col;
        for (int e = 0; e < HIDDEN_SZ; e++) begin
            col[e*BW +: BW] = BW'(value);
        end
        return col;
    endfunction

    task automatic checkOutput(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One write-port cycle; returns #1 after the edge that samples it.
    task automatic applyStimulus(input logic [1:0] sel, input int addr, input logic [LW-1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AWY'(addr);
        wr_data = data;
        @(posedge clock); #1;
        wr_en   = 1'b0;
    endtask

    task automatic stepClock(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    // Streams INPUT_SZ+HIDDEN_SZ elements; element k carries elemBase+k for k<8, else hValue.
    task automatic streamFrame(input int elemBase, input int hValue, input bit toggle,
                               input bit glitchReady, output int accepts);
        int  cyc;
        bit  accept;
        bit  pulsed;
        accepts = 0;
        cyc     = 0;
        pulsed  = 1'b0;
        while (accepts < INPUT_SZ + HIDDEN_SZ && cyc < 200) begin
            vec_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            vec_data  = (accepts < INPUT_SZ) ? BW'(elemBase + accepts) : BW'(hValue);
            if (glitchReady && !pulsed && accepts == INPUT_SZ + 4) begin
                dataReady_gate = 1'b1;
                gateOutput     = splat(77);
                pulsed         = 1'b1;
            end else begin
                dataReady_gate = 1'b0;
            end
            accept = vec_valid && vec_ready;
            @(posedge clock); #1;
            if (accept) accepts++;
            cyc++;
        end
        vec_valid      = 1'b0;
        dataReady_gate = 1'b0;
    endtask

    localparam logic [LW-1:0] PAT = {HIDDEN_SZ{18'h00123}};

    initial begin
        int accepts;
        nVectors       = 0;
        nMiscompares   = 0;
        reset          = 1'b1;
        vec_valid      = 1'b0;
        vec_data       = '0;
        wr_en          = 1'b0;
        wr_sel         = 2'd0;
        wr_addr        = '0;
        wr_data        = '0;
        colAddress_X   = '0;
        colAddress_Y   = '0;
        dataReady_gate = 1'b0;
        gateOutput     = '0;
        res_ready      = 1'b0;

        stepClock(2);
        checkOutput("rstVecReady", LW'(vec_ready), '0);
        checkOutput("rstBusy", LW'(busy), '0);
        checkOutput("rstResValid", LW'(res_valid), '0);
        checkOutput("rstResData", res_data, '0);
        checkOutput("rstBias", biasVec, '0);
        reset = 1'b0;
        stepClock(1);
        checkOutput("vecReadyAfterRst", LW'(vec_ready), LW'(1));

        for (int k = 0; k < INPUT_SZ; k++) applyStimulus(2'd0, k, splat(k + 1));
        for (int k = 0; k < HIDDEN_SZ; k++) applyStimulus(2'd1, k, splat(2 * k));
        applyStimulus(2'd2, 0, '0);
        checkOutput("wrErrGoodWrite", LW'(wr_err), '0);
        applyStimulus(2'd3, 1, splat(9));
        checkOutput("wrErrReserved", LW'(wr_err), LW'(1));
        stepClock(1);
        checkOutput("wrErrPulseEnd", LW'(wr_err), '0);

        streamFrame(1, 1, 1'b1, 1'b1, accepts);
        checkOutput("acceptCount", LW'(accepts), LW'(24));
        checkOutput("kickBeginCalc", LW'(beginCalc), LW'(1));
        checkOutput("kickVecReady", LW'(vec_ready), '0);
        checkOutput("kickBusy", LW'(busy), LW'(1));
        stepClock(1);
        checkOutput("waitBeginCalc", LW'(beginCalc), '0);
        checkOutput("glitchIgnored", LW'(res_valid), '0);

        colAddress_X = 3'd3;
        colAddress_Y = 4'd5;
        #1;
        checkOutput("inputVec3", LW'(inputVec), LW'(4));
        checkOutput("weightX3", weightMem_X, splat(4));
        checkOutput("prevOut5", LW'(prevLayerOut), LW'(1));
        checkOutput("weightY5", weightMem_Y, splat(10));
        colAddress_X = 3'd0;
        #1;
        checkOutput("inputVec0", LW'(inputVec), LW'(1));
        colAddress_X = 3'd7;
        colAddress_Y = 4'd15;
        #1;
        checkOutput("inputVec7", LW'(inputVec), LW'(8));
        checkOutput("weightY15", weightMem_Y, splat(30));

        applyStimulus(2'd0, 2, '1);
        checkOutput("wrErrInWait", LW'(wr_err), LW'(1));
        colAddress_X = 3'd2;
        #1;
        checkOutput("weightX2Frozen", weightMem_X, splat(3));
        stepClock(1);
        checkOutput("wrErrWaitEnd", LW'(wr_err), '0);

        dataReady_gate = 1'b1;
        gateOutput     = PAT;
        stepClock(1);
        dataReady_gate = 1'b0;
        gateOutput     = ~PAT;
        checkOutput("resValidHi", LW'(res_valid), LW'(1));
        checkOutput("resDataCapture", res_data, PAT);
        for (int i = 0; i < 5; i++) begin
            stepClock(1);
            checkOutput("resDataStable", res_data, PAT);
            checkOutput("resValidHeld", LW'(res_valid), LW'(1));
        end
        res_ready = 1'b1;
        stepClock(1);
        res_ready = 1'b0;
        checkOutput("resValidDrop", LW'(res_valid), '0);
        checkOutput("doneBusy", LW'(busy), '0);
        checkOutput("doneVecReady", LW'(vec_ready), LW'(1));

        streamFrame(100, 2, 1'b0, 1'b0, accepts);
        checkOutput("frame2Accepts", LW'(accepts), LW'(24));
        stepClock(1);
        colAddress_X = 3'd0;
        #1;
        checkOutput("frame2X0", LW'(inputVec), LW'(100));
        checkOutput("frame2Busy", LW'(busy), LW'(1));
        reset = 1'b1;
        #1;
        checkOutput("midRstBusy", LW'(busy), '0);
        checkOutput("midRstResValid", LW'(res_valid), '0);
        stepClock(1);
        reset = 1'b0;
        stepClock(1);
        colAddress_X = 3'd3;
        #1;
        checkOutput("postRstVecReady", LW'(vec_ready), LW'(1));
        checkOutput("postRstResValid", LW'(res_valid), '0);
        checkOutput("postRstBusy", LW'(busy), '0);
        checkOutput("postRstXbuf", LW'(inputVec), '0);
        checkOutput("postRstWeightX3", weightMem_X, splat(4));

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
